pipelined_barrel_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 43 ++++
 rtl/pipelined_barrel_shifter_stage.sv | 58 +++++
 rtl/pipelined_barrel_shifter.sv | 104 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
//   shift_op_e  : operation encoding carried on in_op (codes 101..111 reserved)
//   is_right    : op runs on a bit-reversed operand
//   is_rotate   : op wraps bits instead of filling
//   is_reserved : op is one of the unused codes (pass-through)
//   bit_reverse : reverse the low w bits of a MAX_W-wide vector
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_op_e;

  // Widest operand the reversal helper supports.
  localparam int unsigned MAX_W   = 128;
  localparam int unsigned MAX_SHW = $clog2(MAX_W);

  function automatic logic is_right(input logic [2:0] op);
    return (op == SRL) || (op == SRA) || (op == ROR);
  endfunction

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == ROL) || (op == ROR);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op > ROR;
  endfunction

  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d,
                                                   input int unsigned     w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[MAX_SHW'(i)] = d[MAX_SHW'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One mux level of the barrel shifter: shifts left by DIST when sh is set,
// filling with the fill bit or wrapping when rot is set. With REGISTERED = 1
// the result and the rank sideband are captured when en is high; otherwise
// the level is purely combinational.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : rank advance enable
//   d / q      : partial data in / out
//   sh         : shift this level
//   fill, rot  : fill bit, rotate flag
//   sb_d/sb_q  : sideband (valid, fill, op, shamt, tag) in / out
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SB_W       = 1,
  parameter int unsigned DIST       = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             sh,
  input  logic             fill,
  input  logic             rot,
  input  logic [SB_W-1:0]  sb_d,
  output logic [WIDTH-1:0] q,
  output logic [SB_W-1:0]  sb_q
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = d;
    if (sh) begin
      if (rot) shifted = {d[WIDTH-DIST-1:0], d[WIDTH-1 -: DIST]};
      else     shifted = {d[WIDTH-DIST-1:0], {DIST{fill}}};
    end
  end

  if (REGISTERED) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q    <= '0;
        sb_q <= '0;
      end else if (en) begin
        q    <= shifted;
        sb_q <= sb_d;
      end
    end
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign q    = shifted;
    assign sb_q = sb_d;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake.
// Right ops reverse the operand, run through SHW left-shift levels and
// reverse the result, so one left-shift datapath serves all five ops.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake
//   in_data, in_shamt     : operand and shift amount
//   in_op, in_tag         : operation (shift_op_e) and sideband tag
//   out_valid/out_ready   : result handshake
//   out_data, out_tag     : result and its tag
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH     = 16,
  parameter  int unsigned REG_EVERY = 1,
  parameter  int unsigned TAG_W     = 4,
  localparam int unsigned SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || WIDTH > MAX_W) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 2..%0d", MAX_W);
  end
  if (REG_EVERY < 1 || REG_EVERY > SHW) begin : g_bad_reg_every
    $error("pipelined_barrel_shifter: REG_EVERY must be in 1..SHW");
  end

  // Sideband layout, MSB first: valid, fill, op[2:0], shamt, tag.
  localparam int unsigned SB_W   = 5 + SHW + TAG_W;
  localparam int unsigned SB_SH  = TAG_W;
  localparam int unsigned SB_OP  = TAG_W + SHW;
  localparam int unsigned SB_FIL = TAG_W + SHW + 3;

  logic             adv;
  logic [WIDTH-1:0] dat [SHW+1];
  logic [SB_W-1:0]  sb  [SHW+1];
  logic [WIDTH-1:0] d0;
  logic [SHW-1:0]   shamt0;
  logic             fill0;
  logic [2:0]       op_out;

  assign out_valid = sb[SHW][SB_W-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_comb begin
    shamt0 = is_reserved(in_op) ? '0 : in_shamt;
    fill0  = (in_op == SRA) && in_data[WIDTH-1];
    d0     = in_data;
    if (is_right(in_op)) d0 = WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH));
    // Bubbles carry zero data so an idle output reads 0.
    if (!in_valid) d0 = '0;
  end

  assign dat[0] = d0;
  assign sb[0]  = {in_valid, fill0, in_op, shamt0, in_tag};

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam bit REG = (((k + 1) % REG_EVERY) == 0) || (k == SHW - 1);
    logic [2:0] op_k;
    assign op_k = sb[k][SB_OP +: 3];

    shift_stage #(
      .WIDTH      (WIDTH),
      .SB_W       (SB_W),
      .DIST       (1 << k),
      .REGISTERED (REG)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .d     (dat[k]),
      .sh    (sb[k][SB_SH + k]),
      .fill  (sb[k][SB_FIL]),
      .rot   (is_rotate(op_k)),
      .sb_d  (sb[k]),
      .q     (dat[k+1]),
      .sb_q  (sb[k+1])
    );
  end

  assign op_out  = sb[SHW][SB_OP +: 3];
  assign out_tag = sb[SHW][TAG_W-1:0];

  always_comb begin
    out_data = dat[SHW];
    if (is_right(op_out)) out_data = WIDTH'(bit_reverse(MAX_W'(dat[SHW]), WIDTH));
  end

  logic unused_sb;
  assign unused_sb = ^{sb[SHW][SB_FIL], sb[SHW][SB_SH +: SHW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned n_out   = 0;
  int unsigned n_done  = 0;
  bit          sb_on   = 0;
  bit          chk_lat = 0;
  bit          go      = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int unsigned cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t sb_e;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d;
    logic [3:0]  s;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[12];

  pipelined_barrel_shifter #(.WIDTH(16), .REG_EVERY(1), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: straightforward shift/rotate arithmetic on a w-bit value.
  function automatic logic [63:0] model(input logic [63:0] d, input int unsigned s,
                                        input logic [2:0] op, input int unsigned w);
    logic [63:0] m, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = d & m;
    case (op)
      3'd0: r = d << s;
      3'd1: r = d >> s;
      3'd2: r = (d >> s) | ((((d >> (w - 1)) & 64'd1) != 0) ? (m & ~(m >> s)) : 64'd0);
      3'd3: r = (d << s) | (d >> (w - s));
      3'd4: r = (d >> s) | (d << (w - s));
      default: r = d;
    endcase
    return r & m;
  endfunction

  // Scoreboard monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      if (in_valid && in_ready)
        sbq.push_back('{16'(model(64'(in_data), 32'(in_shamt), in_op, 16)), in_tag, cyc});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "spurious_out", 64'({out_tag, out_data}), 64'd0);
        end else begin
          sb_e = sbq.pop_front();
          n_out++;
          chk(out_data == sb_e.data && out_tag == sb_e.tag, "sb_result",
              64'({out_tag, out_data}), 64'({sb_e.tag, sb_e.data}));
          if (chk_lat) chk(cyc - sb_e.cyc == 4, "sb_latency", 64'(cyc - sb_e.cyc), 64'd4);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] s,
                      input logic [2:0] op, input logic [3:0] t);
    bit acc;
    int unsigned n;
    in_data = d; in_shamt = s; in_op = op; in_tag = t; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk(1'b0, "send_timeout", 64'(n), 64'd50);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(sbq.size() == 0, "drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input vec_t v, input logic [3:0] t);
    int unsigned lat;
    in_data = v.d; in_shamt = v.s; in_op = v.op; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    chk(in_ready, "tbl_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(out_valid && out_data == v.exp && out_tag == t, "tbl_result",
        64'({out_valid, out_tag, out_data}), 64'({1'b1, t, v.exp}));
    chk(lat == 4, "tbl_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;
  endtask

  // Parameter sweep instances: one operand at a time, checked for value and latency.
  localparam int unsigned CW [5] = '{8, 8, 8, 32, 64};
  localparam int unsigned CR [5] = '{1, 2, 3, 2, 6};

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int unsigned W   = CW[g];
    localparam int unsigned R   = CR[g];
    localparam int unsigned SH  = $clog2(W);
    localparam int unsigned LAT = (SH + R - 1) / R;

    logic          v_i, r_i, v_o;
    logic [W-1:0]  d_i, d_o;
    logic [SH-1:0] s_i;
    logic [2:0]    o_i;
    logic [3:0]    t_i, t_o;

    pipelined_barrel_shifter #(.WIDTH(W), .REG_EVERY(R), .TAG_W(4)) u_sw (
      .clk       (clk),
      .rst_n     (rst2_n),
      .in_valid  (v_i),
      .in_ready  (r_i),
      .in_data   (d_i),
      .in_shamt  (s_i),
      .in_op     (o_i),
      .in_tag    (t_i),
      .out_valid (v_o),
      .out_ready (1'b1),
      .out_data  (d_o),
      .out_tag   (t_o)
    );

    initial begin
      logic [63:0] rd, ex;
      int unsigned lat;
      v_i = 1'b0; d_i = '0; s_i = '0; o_i = '0; t_i = '0;
      wait (go);
      for (int i = 0; i < 25; i++) begin
        rd  = {$urandom, $urandom};
        d_i = W'(rd);
        s_i = SH'($urandom_range(W - 1, 1));
        o_i = (i == 24) ? 3'b101 : 3'($urandom_range(4, 0));
        t_i = 4'(i);
        ex  = model(64'(d_i), 32'(s_i), o_i, W);
        v_i = 1'b1;
        @(negedge clk);
        chk(r_i, $sformatf("sw%0d_%0d_ready", W, R), 64'(r_i), 64'd1);
        @(posedge clk); #1;
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        chk(v_o && d_o == W'(ex) && t_o == t_i, $sformatf("sw%0d_%0d_op%0d", W, R, o_i),
            64'(d_o), ex);
        chk(lat == LAT, $sformatf("sw%0d_%0d_latency", W, R), 64'(lat), 64'(LAT));
        @(posedge clk); #1;
      end
      n_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] hd;
    logic [3:0]  ht;
    int unsigned n;

    tbl[0]  = '{3'd0, 16'h4F8D, 4'd4,  16'hF8D0};
    tbl[1]  = '{3'd1, 16'h4F8D, 4'd4,  16'h04F8};
    tbl[2]  = '{3'd3, 16'h4F8D, 4'd4,  16'hF8D4};
    tbl[3]  = '{3'd4, 16'h4F8D, 4'd4,  16'hD4F8};
    tbl[4]  = '{3'd2, 16'h8F8D, 4'd4,  16'hF8F8};
    tbl[5]  = '{3'd2, 16'h4F8D, 4'd15, 16'h0000};
    tbl[6]  = '{3'd2, 16'h8000, 4'd15, 16'hFFFF};
    tbl[7]  = '{3'd0, 16'h0001, 4'd15, 16'h8000};
    tbl[8]  = '{3'd4, 16'h0001, 4'd1,  16'h8000};
    tbl[9]  = '{3'd3, 16'h8001, 4'd15, 16'hC000};
    tbl[10] = '{3'd5, 16'h4F8D, 4'd7,  16'h4F8D};
    tbl[11] = '{3'd1, 16'h4F8D, 4'd0,  16'h4F8D};

    rst_n = 1'b0; rst2_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(!out_valid && out_data == 16'h0 && out_tag == 4'h0 && in_ready, "reset_state",
        64'({in_ready, out_valid, out_tag, out_data}), 64'({1'b1, 1'b0, 4'h0, 16'h0}));
    rst_n = 1'b1; rst2_n = 1'b1;

    for (int i = 0; i < 12; i++) run_one(tbl[i], 4'(i));

    // Back-to-back sweep of every op and shift amount.
    sb_on = 1'b1; chk_lat = 1'b1; n_out = 0;
    for (int op = 0; op < 5; op++)
      for (int s = 0; s < 16; s++)
        send(16'h4F8D, 4'(s), 3'(op), 4'(s));
    drain();
    chk(n_out == 80, "sweep_count", 64'(n_out), 64'd80);

    // Backpressure: stall the consumer for 6 cycles mid-stream.
    chk_lat = 1'b0; n_out = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom), 4'($urandom_range(15, 0)), 3'($urandom_range(4, 0)), 4'(i));
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk(out_valid, "bp_first_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        hd = out_data; ht = out_tag;
        repeat (6) begin
          @(negedge clk);
          chk(out_valid && !in_ready && out_data == hd && out_tag == ht, "bp_stall_hold",
              64'({out_valid, in_ready, out_tag, out_data}), 64'({1'b1, 1'b0, ht, hd}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk(n_out == 8, "bp_count", 64'(n_out), 64'd8);

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) send(16'h1234 + 16'(i), 4'(i + 1), 3'd0, 4'(i));
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    chk(!out_valid && out_data == 16'h0 && in_ready, "midreset_state",
        64'({in_ready, out_valid, out_data}), 64'({1'b1, 1'b0, 16'h0}));
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk(n == 0, "midreset_no_stale", 64'(n), 64'd0);
    sb_on = 1'b0;

    // Parameter sweep instances.
    rst2_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst2_n = 1'b1;
    go = 1'b1;
    n = 0;
    while (n_done < 5 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(n_done == 5, "sweep_done", 64'(n_done), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
